// File: rtl/board_io_irq_if.sv
// Wishbone (16-bit data, 4-bit word address) bundle between a bus master and the
// board I/O slave. Signal names follow the board I/O pin list.
interface board_io_irq_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_adr;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack, wb_stall
  );
endinterface

// File: rtl/board_io_irq.sv
// Evaluation-board I/O slave: debounced keys/switches, LED and seven-segment output
// registers, sticky key-press pending bits with a maskable level interrupt, all
// reachable over a zero-wait-state 16-bit Wishbone slave with registered read data.
module board_io_irq #(
  parameter int N_KEY   = 4,
  parameter int N_SW    = 10,
  parameter int N_LEDG  = 8,
  parameter int N_LEDR  = 10,
  parameter int N_HEX   = 4,
  parameter int DEB_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_KEY-1:0]      key,
  input  logic [N_SW-1:0]       sw,
  output logic [N_HEX-1:0][6:0] hex,
  output logic [N_LEDG-1:0]     ledg,
  output logic [N_LEDR-1:0]     ledr,
  output logic                  irq,
  board_io_irq_if.slave         wb
);

  // Keys and switches share one debounce array: keys occupy the low bits.
  localparam int NIN = N_KEY + N_SW;
  localparam int CW  = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic [N_KEY-1:0]      key_s1_q, key_s2_q;
  logic [N_SW-1:0]       sw_s1_q, sw_s2_q;
  logic [NIN-1:0]        in_sync;
  logic [NIN-1:0]        deb_q, deb_d;
  logic [CW-1:0]         cnt_q [NIN];
  logic [CW-1:0]         cnt_d [NIN];

  logic [N_KEY-1:0]      key_deb;
  logic [N_SW-1:0]       sw_deb;
  logic [N_KEY-1:0]      key_prev_q, key_rise;
  logic [N_KEY-1:0]      pend_q, pend_d, pend_clr;
  logic [N_KEY-1:0]      mask_q, mask_d;
  logic [N_LEDG-1:0]     ledg_q, ledg_d;
  logic [N_LEDR-1:0]     ledr_q, ledr_d;
  logic [N_HEX-1:0][6:0] hex_q, hex_d;

  logic                  valid, wr, rd;
  logic [15:0]           rdata;
  logic                  ack_q;
  logic [15:0]           dat_q, dat_d;

  // Write-data bits above the configured register widths are deliberately ignored.
  logic                  unused_wdat;
  assign unused_wdat = ^wb.wb_dat_i;

  // Two-flop synchronisers on the raw pins; keys are kept in pin polarity here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Keys become active-high (1 = pressed) only after synchronisation.
  assign in_sync = {sw_s2_q, ~key_s2_q};

  // Per-bit debounce: count consecutive disagreeing cycles, flip on the last one;
  // any agreeing cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (in_sync[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = in_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign key_deb  = deb_q[N_KEY-1:0];
  assign sw_deb   = deb_q[NIN-1:N_KEY];
  assign key_rise = key_deb & ~key_prev_q;

  assign valid = wb.wb_cyc & wb.wb_stb;
  assign wr    = valid & wb.wb_we;
  assign rd    = valid & ~wb.wb_we;

  // Register writes and pending-bit update; a press in the same cycle beats W1C.
  always_comb begin
    mask_d   = mask_q;
    ledg_d   = ledg_q;
    ledr_d   = ledr_q;
    hex_d    = hex_q;
    pend_clr = '0;
    if (wr) begin
      case (wb.wb_adr)
        4'd2:    pend_clr = wb.wb_dat_i[N_KEY-1:0];
        4'd3:    mask_d   = wb.wb_dat_i[N_KEY-1:0];
        4'd4:    ledg_d   = wb.wb_dat_i[N_LEDG-1:0];
        4'd5:    ledr_d   = wb.wb_dat_i[N_LEDR-1:0];
        default: ;
      endcase
      for (int n = 0; n < N_HEX; n++) begin
        if (wb.wb_adr == 4'(8 + n)) hex_d[n] = ~wb.wb_dat_i[6:0];
      end
    end
    pend_d = (pend_q & ~pend_clr) | key_rise;
  end

  // Read multiplexer; segment registers read back in active-high form.
  always_comb begin
    rdata = '0;
    case (wb.wb_adr)
      4'd0:    rdata = 16'(key_deb);
      4'd1:    rdata = 16'(sw_deb);
      4'd2:    rdata = 16'(pend_q);
      4'd3:    rdata = 16'(mask_q);
      4'd4:    rdata = 16'(ledg_q);
      4'd5:    rdata = 16'(ledr_q);
      default: ;
    endcase
    for (int n = 0; n < N_HEX; n++) begin
      if (wb.wb_adr == 4'(8 + n)) rdata = {9'd0, ~hex_q[n]};
    end
    dat_d = rd ? rdata : 16'h0000;
  end

  // Output registers, interrupt state and the single-cycle bus response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledg_q     <= '0;
      ledr_q     <= '0;
      hex_q      <= '1;
      mask_q     <= '0;
      pend_q     <= '0;
      key_prev_q <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      ledg_q     <= ledg_d;
      ledr_q     <= ledr_d;
      hex_q      <= hex_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      key_prev_q <= key_deb;
      ack_q      <= valid;
      dat_q      <= dat_d;
    end
  end

  assign ledg        = ledg_q;
  assign ledr        = ledr_q;
  assign hex         = hex_q;
  assign irq         = |(pend_q & mask_q);
  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_stall = 1'b0;

endmodule

// File: tb/tb_board_io_irq.sv
// Bench for board_io_irq with a short debounce window: table-driven bus vectors,
// directed debounce/interrupt sequences, and randomized traffic scored every cycle
// against a behavioural model built from the register-level description.
module tb_board_io_irq;
  localparam int NK  = 4;
  localparam int NS  = 10;
  localparam int NG  = 8;
  localparam int NR  = 10;
  localparam int NH  = 4;
  localparam int DEB = 4;

  logic                clk;
  logic                reset_n;
  logic [NK-1:0]       key;
  logic [NS-1:0]       sw;
  logic [NH-1:0][6:0]  hex;
  logic [NG-1:0]       ledg;
  logic [NR-1:0]       ledr;
  logic                irq;

  board_io_irq_if wb_bus();

  board_io_irq #(
    .N_KEY(NK), .N_SW(NS), .N_LEDG(NG), .N_LEDR(NR), .N_HEX(NH), .DEB_CYC(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .sw(sw), .hex(hex),
    .ledg(ledg), .ledr(ledr), .irq(irq), .wb(wb_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin history per edge: h[0] is the pin seen at the previous edge, h[j] j edges older.
  // A debounced bit flips when the DEB samples that reach it (h[1..DEB]) all disagree.
  logic [NK-1:0] m_hk [0:DEB];
  logic [NS-1:0] m_hs [0:DEB];
  logic [NK-1:0] m_deb_k, m_prev_k, m_pend, m_mask, m_clr;
  logic [NS-1:0] m_deb_s;
  logic [NG-1:0] m_ledg;
  logic [NR-1:0] m_ledr;
  logic [6:0]    m_hex [NH];
  logic          m_ack, m_v, m_all;
  logic [15:0]   m_dat;

  function automatic logic [15:0] m_read(input logic [3:0] a);
    int ai = int'(a);
    if (ai == 0) return 16'(m_deb_k);
    if (ai == 1) return 16'(m_deb_s);
    if (ai == 2) return 16'(m_pend);
    if (ai == 3) return 16'(m_mask);
    if (ai == 4) return 16'(m_ledg);
    if (ai == 5) return 16'(m_ledr);
    if (ai >= 8 && ai < 8 + NH) return {9'd0, m_hex[ai-8]};
    return 16'h0000;
  endfunction

  function automatic logic [NH*7-1:0] m_hex_pins();
    logic [NH*7-1:0] v;
    for (int n = 0; n < NH; n++) v[n*7 +: 7] = ~m_hex[n];
    return v;
  endfunction

  task automatic m_reset();
    m_deb_k = '0; m_prev_k = '0; m_pend = '0; m_mask = '0; m_deb_s = '0;
    m_ledg = '0; m_ledr = '0; m_ack = 1'b0; m_dat = '0;
    for (int n = 0; n < NH; n++) m_hex[n] = 7'h00;
    // Synchroniser stages hold pin value 0; older history counts as "no disagreement".
    for (int j = 0; j <= DEB; j++) begin
      m_hk[j] = (j < 2) ? '0 : '1;
      m_hs[j] = '0;
    end
  endtask

  task automatic m_step();
    int ai;
    m_v   = wb_bus.wb_cyc & wb_bus.wb_stb;
    m_ack = m_v;
    m_dat = (m_v && !wb_bus.wb_we) ? m_read(wb_bus.wb_adr) : 16'h0000;
    m_clr = '0;
    if (m_v && wb_bus.wb_we) begin
      ai = int'(wb_bus.wb_adr);
      if (ai == 2) m_clr  = wb_bus.wb_dat_i[NK-1:0];
      if (ai == 3) m_mask = wb_bus.wb_dat_i[NK-1:0];
      if (ai == 4) m_ledg = wb_bus.wb_dat_i[NG-1:0];
      if (ai == 5) m_ledr = wb_bus.wb_dat_i[NR-1:0];
      if (ai >= 8 && ai < 8 + NH) m_hex[ai-8] = wb_bus.wb_dat_i[6:0];
    end
    m_pend   = (m_pend & ~m_clr) | (m_deb_k & ~m_prev_k);
    m_prev_k = m_deb_k;
    for (int b = 0; b < NK; b++) begin
      m_all = 1'b1;
      for (int j = 1; j <= DEB; j++) if ((~m_hk[j][b]) == m_deb_k[b]) m_all = 1'b0;
      if (m_all) m_deb_k[b] = ~m_deb_k[b];
    end
    for (int b = 0; b < NS; b++) begin
      m_all = 1'b1;
      for (int j = 1; j <= DEB; j++) if (m_hs[j][b] == m_deb_s[b]) m_all = 1'b0;
      if (m_all) m_deb_s[b] = ~m_deb_s[b];
    end
    for (int j = DEB; j >= 1; j--) begin
      m_hk[j] = m_hk[j-1];
      m_hs[j] = m_hs[j-1];
    end
    m_hk[0] = key;
    m_hs[0] = sw;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_ack", 32'(wb_bus.wb_ack), 32'(m_ack));
        chk("model_dat", 32'(wb_bus.wb_dat_o), 32'(m_dat));
        chk("model_irq", 32'(irq), 32'(|(m_pend & m_mask)));
        chk("model_ledg", 32'(ledg), 32'(m_ledg));
        chk("model_ledr", 32'(ledr), 32'(m_ledr));
        chk("model_hex", 32'(hex), 32'(m_hex_pins()));
        chk("model_stall", 32'(wb_bus.wb_stall), 32'd0);
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input logic we, input logic [3:0] adr, input logic [15:0] dat,
                     output logic ack, output logic [15:0] rdv);
    wb_bus.wb_cyc   = 1'b1;
    wb_bus.wb_stb   = 1'b1;
    wb_bus.wb_we    = we;
    wb_bus.wb_adr   = adr;
    wb_bus.wb_dat_i = dat;
    @(posedge clk);
    #1;
    ack = wb_bus.wb_ack;
    rdv = wb_bus.wb_dat_o;
  endtask

  task automatic idle();
    wb_bus.wb_cyc = 1'b0;
    wb_bus.wb_stb = 1'b0;
    wb_bus.wb_we  = 1'b0;
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  adr;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [16];
  logic        a;
  logic [15:0] r;

  initial begin
    tbl[0]  = '{we: 1'b1, adr: 4'd4,  dat: 16'h00A5, exp: 16'h0000};
    tbl[1]  = '{we: 1'b0, adr: 4'd4,  dat: 16'h0000, exp: 16'h00A5};
    tbl[2]  = '{we: 1'b1, adr: 4'd5,  dat: 16'h03FF, exp: 16'h0000};
    tbl[3]  = '{we: 1'b0, adr: 4'd5,  dat: 16'h0000, exp: 16'h03FF};
    tbl[4]  = '{we: 1'b0, adr: 4'd8,  dat: 16'h0000, exp: 16'h0000};
    tbl[5]  = '{we: 1'b1, adr: 4'd9,  dat: 16'h003F, exp: 16'h0000};
    tbl[6]  = '{we: 1'b0, adr: 4'd9,  dat: 16'h0000, exp: 16'h003F};
    tbl[7]  = '{we: 1'b0, adr: 4'd6,  dat: 16'h0000, exp: 16'h0000};
    tbl[8]  = '{we: 1'b0, adr: 4'd7,  dat: 16'h0000, exp: 16'h0000};
    tbl[9]  = '{we: 1'b0, adr: 4'd15, dat: 16'h0000, exp: 16'h0000};
    tbl[10] = '{we: 1'b1, adr: 4'd6,  dat: 16'hFFFF, exp: 16'h0000};
    tbl[11] = '{we: 1'b1, adr: 4'd7,  dat: 16'hFFFF, exp: 16'h0000};
    tbl[12] = '{we: 1'b1, adr: 4'd15, dat: 16'hFFFF, exp: 16'h0000};
    tbl[13] = '{we: 1'b1, adr: 4'd12, dat: 16'hFFFF, exp: 16'h0000};
    tbl[14] = '{we: 1'b0, adr: 4'd12, dat: 16'h0000, exp: 16'h0000};
    tbl[15] = '{we: 1'b0, adr: 4'd4,  dat: 16'h0000, exp: 16'h00A5};

    reset_n = 1'b0;
    key     = '1;
    sw      = '0;
    wb_bus.wb_adr   = '0;
    wb_bus.wb_dat_i = '0;
    idle();
    cyc_wait(3);
    chk("rst_ledg", 32'(ledg), 32'h0);
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_hex", 32'(hex), 32'hFFFFFFF);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ack", 32'(wb_bus.wb_ack), 32'h0);
    chk("rst_dat", 32'(wb_bus.wb_dat_o), 32'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    cyc_wait(8);

    // Back-to-back table of writes/reads, including unmapped addresses.
    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat, a, r);
      chk($sformatf("tbl_ack_%0d", i), 32'(a), 32'h1);
      chk($sformatf("tbl_dat_%0d", i), 32'(r), 32'(tbl[i].exp));
    end
    idle();
    cyc_wait(1);
    chk("ack_drop", 32'(wb_bus.wb_ack), 32'h0);
    chk("ledg_a5", 32'(ledg), 32'hA5);
    chk("ledr_3ff", 32'(ledr), 32'h3FF);
    chk("hex_pins", 32'(hex), 32'({7'h7F, 7'h7F, 7'h40, 7'h7F}));

    // key[2]: low 3 cycles, high 1, then steady low; KEY reads polled every cycle.
    key[2] = 1'b0;
    cyc_wait(3);
    key[2] = 1'b1;
    cyc_wait(1);
    key[2] = 1'b0;
    for (int j = 5; j <= 12; j++) begin
      bus(1'b0, 4'd0, 16'h0, a, r);
      chk($sformatf("key_deb_e%0d", j), 32'(r), (j >= 11) ? 32'h4 : 32'h0);
    end
    bus(1'b0, 4'd2, 16'h0, a, r);
    chk("pend_after_press", 32'(r), 32'h4);
    idle();
    cyc_wait(1);
    chk("irq_unmasked_0", 32'(irq), 32'h0);

    bus(1'b1, 4'd3, 16'h0004, a, r);
    chk("irq_masked_1", 32'(irq), 32'h1);
    bus(1'b1, 4'd2, 16'h0004, a, r);
    chk("irq_w1c_0", 32'(irq), 32'h0);
    idle();

    // Release does not set pending.
    key[2] = 1'b1;
    cyc_wait(10);
    bus(1'b0, 4'd2, 16'h0, a, r);
    chk("pend_release", 32'(r), 32'h0);
    idle();

    // New press whose pending edge coincides with a W1C write: press wins.
    key[2] = 1'b0;
    cyc_wait(6);
    bus(1'b1, 4'd2, 16'h0004, a, r);
    bus(1'b0, 4'd2, 16'h0, a, r);
    chk("pend_press_wins", 32'(r), 32'h4);
    chk("irq_press_wins", 32'(irq), 32'h1);
    idle();

    // Stable switches read back-to-back.
    sw = 10'h155;
    cyc_wait(10);
    for (int j = 0; j < 4; j++) begin
      bus(1'b0, 4'd1, 16'h0, a, r);
      chk($sformatf("sw_ack_%0d", j), 32'(a), 32'h1);
      chk($sformatf("sw_dat_%0d", j), 32'(r), 32'h155);
      chk($sformatf("sw_stall_%0d", j), 32'(wb_bus.wb_stall), 32'h0);
    end

    // Asynchronous reset in the middle of a bus cycle.
    bus(1'b1, 4'd4, 16'h005A, a, r);
    wb_bus.wb_adr   = 4'd5;
    wb_bus.wb_dat_i = 16'h0123;
    key = '1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ledg", 32'(ledg), 32'h0);
    chk("mid_rst_ledr", 32'(ledr), 32'h0);
    chk("mid_rst_hex", 32'(hex), 32'hFFFFFFF);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_ack", 32'(wb_bus.wb_ack), 32'h0);
    chk("mid_rst_dat", 32'(wb_bus.wb_dat_o), 32'h0);
    @(posedge clk);
    #1;
    idle();
    reset_n = 1'b1;
    cyc_wait(4);

    // Randomized pins and bus traffic, scored by the model every cycle.
    for (int c = 0; c < 2000; c++) begin
      int b;
      if ($urandom_range(5) == 0) begin
        b = $urandom_range(NS - 1);
        sw[b] = ~sw[b];
      end
      if ($urandom_range(5) == 0) begin
        b = $urandom_range(NK - 1);
        key[b] = ~key[b];
      end
      wb_bus.wb_cyc   = ($urandom_range(3) != 0);
      wb_bus.wb_stb   = ($urandom_range(3) != 0);
      wb_bus.wb_we    = $urandom_range(1) == 1;
      wb_bus.wb_adr   = 4'($urandom_range(15));
      wb_bus.wb_dat_i = 16'($urandom);
      cyc_wait(1);
    end
    idle();
    cyc_wait(2);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
